// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder: FSM states, the latched
// request record and the address legality check.
package dmem_responder_pkg;

    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } rsp_state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    // True when the byte address is misaligned or lies beyond the last word.
    function automatic logic access_err(input logic [31:0] addr, input int unsigned depth);
        return (addr[1:0] != 2'b00) || (addr >= WORD_BYTES * depth);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Data-memory bus: valid/ready request channel (master -> responder) and
// valid/ready response channel (responder -> master).
interface dmem_responder_if;

    // Handshake: a beat transfers on a rising clk edge where valid and ready are both
    // high; the source holds its payload stable while valid is high and ready is low.
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_responder_word_ram.sv
// Word-indexed storage: synchronous write, asynchronous read. Contents are not reset.
module dmem_responder_word_ram #(
  parameter int DEPTH   = 64,
  parameter     MEMFILE = "",
  parameter int AW      = 6
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder: accepts one load/store, waits WAIT_CYCLES, performs the access
// on entry to RESP and holds the response until the master takes it.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2,
    parameter     MEMFILE     = ""
) (
    input  logic              clk,
    input  logic              reset,
    dmem_responder_if.slave   bus,
    output rsp_state_t        o_state
);

    localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    rsp_state_t  r_state;
    rsp_state_t  w_next;
    mem_req_t    r_req;
    mem_req_t    w_op;
    logic [3:0]  r_cnt;
    logic [31:0] r_rdata;
    logic        r_err;
    logic        w_accept;
    logic        w_commit;
    logic        w_bad;
    logic        w_ram_we;
    logic [31:0] w_ram_rdata;
    logic [AW-1:0] w_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // w_commit marks the edge that enters RESP, where the RAM access happens.
    always_comb begin
        w_next        = r_state;
        w_accept      = 1'b0;
        w_commit      = 1'b0;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        case (r_state)
            IDLE: begin
                bus.req_ready = ~reset;
                w_accept      = bus.req_valid & ~reset;
                if (w_accept) begin
                    if (WAIT_CYCLES == 0) begin
                        w_next   = RESP;
                        w_commit = 1'b1;
                    end else begin
                        w_next   = WAIT;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next   = RESP;
                    w_commit = 1'b1;
                end
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // With zero wait states the access happens on the acceptance edge, so the live
    // request is used while idle and the latched copy otherwise.
    assign w_op     = (r_state == IDLE) ? {bus.req_we, bus.req_addr, bus.req_wdata} : r_req;
    assign w_bad    = access_err(w_op.addr, DEPTH);
    assign w_idx    = w_op.addr[AW+1:2];
    assign w_ram_we = w_commit & w_op.we & ~w_bad;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req <= '0;
            r_cnt <= 4'd0;
        end else if (w_accept) begin
            r_req <= w_op;
            r_cnt <= CNT_INIT;
        end else if (r_state == WAIT && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else if (w_commit) begin
            r_err   <= w_bad;
            r_rdata <= (w_bad || w_op.we) ? 32'd0 : w_ram_rdata;
        end
    end

    dmem_responder_word_ram #(
        .DEPTH   (DEPTH),
        .MEMFILE (MEMFILE),
        .AW      (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_addr  (w_idx),
        .i_wdata (w_op.wdata),
        .o_rdata (w_ram_rdata)
    );

    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;
    assign o_state       = r_state;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a 2-wait-state and a 0-wait-state instance driven by directed
// and random transactions, checked against a word-array model of the memory.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    localparam int DEPTH = 64;

    logic       clk;
    logic       reset;
    rsp_state_t state2;
    rsp_state_t state0;

    int vectors    = 0;
    int miscompares = 0;

    logic [31:0] mdl_mem   [2][DEPTH];
    bit          mdl_known [2][DEPTH];

    dmem_responder_if bus2();
    dmem_responder_if bus0();

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2), .MEMFILE("")) dut2 (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus2),
        .o_state (state2)
    );

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0), .MEMFILE("")) dut0 (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus0),
        .o_state (state0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input bit s, input logic v, input logic we,
                           input logic [31:0] a, input logic [31:0] d);
        if (s) begin
            bus0.req_valid = v; bus0.req_we = we; bus0.req_addr = a; bus0.req_wdata = d;
        end else begin
            bus2.req_valid = v; bus2.req_we = we; bus2.req_addr = a; bus2.req_wdata = d;
        end
    endtask

    task automatic set_rsp_ready(input bit s, input logic r);
        if (s) bus0.rsp_ready = r;
        else   bus2.rsp_ready = r;
    endtask

    function automatic logic get_rdy(input bit s);
        return s ? bus0.req_ready : bus2.req_ready;
    endfunction
    function automatic logic get_vld(input bit s);
        return s ? bus0.rsp_valid : bus2.rsp_valid;
    endfunction
    function automatic logic [31:0] get_rdata(input bit s);
        return s ? bus0.rsp_rdata : bus2.rsp_rdata;
    endfunction
    function automatic logic get_err(input bit s);
        return s ? bus0.rsp_err : bus2.rsp_err;
    endfunction
    function automatic logic [31:0] get_state(input bit s);
        return s ? 32'(state0) : 32'(state2);
    endfunction

    // One full transaction on instance s (0 = 2 wait states, 1 = no wait states).
    // bp = cycles rsp_ready is held low once the response appears; hold_valid keeps
    // req_valid high with changing address while the request is in flight.
    task automatic txn(input bit s, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input int bp, input bit hold_valid,
                       output time acc_t);
        int          w;
        int          lat;
        bit          exp_err;
        bit          known;
        logic [31:0] exp_rd;
        logic [31:0] first_rd;
        int          idx;
        w       = s ? 0 : 2;
        idx     = int'(addr / 4);
        exp_err = (addr % 4 != 0) || (addr >= 4 * DEPTH);
        if (exp_err) begin
            exp_rd = 32'd0; known = 1'b1;
        end else if (we) begin
            exp_rd = 32'd0; known = 1'b1;
            mdl_mem[s][idx] = wdata; mdl_known[s][idx] = 1'b1;
        end else begin
            exp_rd = mdl_mem[s][idx]; known = mdl_known[s][idx];
        end

        set_req(s, 1'b1, we, addr, wdata);
        set_rsp_ready(s, bp == 0);
        chk("req_ready_idle", 32'(get_rdy(s)), 32'd1);
        @(posedge clk);
        acc_t = $time;
        @(negedge clk);
        if (hold_valid) set_req(s, 1'b1, 1'($urandom_range(0, 1)), 4 * $urandom_range(0, 63), $urandom);
        else            set_req(s, 1'b0, 1'b0, 32'd0, 32'd0);
        lat = 1;
        while (!get_vld(s) && lat < 40) begin
            chk("req_ready_wait", 32'(get_rdy(s)), 32'd0);
            @(negedge clk);
            lat++;
            if (hold_valid) set_req(s, 1'b1, 1'($urandom_range(0, 1)), 4 * $urandom_range(0, 63), $urandom);
        end
        chk("latency", 32'(lat), 32'(w + 1));
        chk("rsp_err", 32'(get_err(s)), 32'(exp_err));
        if (known) chk("rsp_rdata", get_rdata(s), exp_rd);
        first_rd = get_rdata(s);
        for (int i = 0; i < bp; i++) begin
            chk("req_ready_resp", 32'(get_rdy(s)), 32'd0);
            @(negedge clk);
            chk("rsp_valid_held", 32'(get_vld(s)), 32'd1);
            chk("rdata_stable", get_rdata(s), first_rd);
            chk("err_stable", 32'(get_err(s)), 32'(exp_err));
        end
        set_rsp_ready(s, 1'b1);
        set_req(s, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk("rsp_valid_done", 32'(get_vld(s)), 32'd0);
        chk("state_idle", get_state(s), 32'(IDLE));
        chk("req_ready_back", 32'(get_rdy(s)), 32'd1);
    endtask

    task automatic chk_reset_outputs(input bit s);
        chk("rst_req_ready", 32'(get_rdy(s)), 32'd0);
        chk("rst_rsp_valid", 32'(get_vld(s)), 32'd0);
        chk("rst_rsp_rdata", get_rdata(s), 32'd0);
        chk("rst_rsp_err", 32'(get_err(s)), 32'd0);
        chk("rst_state", get_state(s), 32'(IDLE));
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 32'(4 * $urandom_range(0, 63) + $urandom_range(1, 3));
        if (r == 1) return 32'(4 * DEPTH + 4 * $urandom_range(0, 100));
        return 32'(4 * $urandom_range(0, 8));
    endfunction

    initial begin
        time t1;
        time t2;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < DEPTH; i++) mdl_known[s][i] = 1'b0;
        reset = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_req(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        set_rsp_ready(1'b0, 1'b1);
        set_rsp_ready(1'b1, 1'b1);
        repeat (3) @(negedge clk);
        chk_reset_outputs(1'b0);
        chk_reset_outputs(1'b1);
        reset = 1'b0;
        #1;
        chk("ready_after_rst", 32'(get_rdy(1'b0)), 32'd1);
        @(negedge clk);

        // Store then load, two wait states.
        txn(1'b0, 1'b1, 32'd100, 32'd7, 0, 1'b0, t1);
        txn(1'b0, 1'b0, 32'd100, 32'd0, 0, 1'b0, t2);
        chk("throughput_w2", 32'((t2 - t1) / 10), 32'd4);

        // Illegal addresses: no RAM effect, even where a misaligned address aliases word 24.
        txn(1'b0, 1'b1, 32'd96, 32'h11, 0, 1'b0, t1);
        txn(1'b0, 1'b0, 32'h62, 32'd0, 0, 1'b0, t1);
        txn(1'b0, 1'b0, 32'd256, 32'd0, 0, 1'b0, t1);
        txn(1'b0, 1'b1, 32'h62, 32'hdead, 0, 1'b0, t1);
        txn(1'b0, 1'b1, 32'd256, 32'hbeef, 0, 1'b0, t1);
        txn(1'b0, 1'b0, 32'd96, 32'd0, 0, 1'b0, t1);

        // Backpressure for five cycles.
        txn(1'b0, 1'b0, 32'd96, 32'd0, 5, 1'b0, t1);

        // Reset while a store sits in WAIT: it must not reach RAM.
        set_req(1'b0, 1'b1, 1'b1, 32'd96, 32'h55);
        @(posedge clk);
        @(negedge clk);
        set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("wait_before_rst", get_state(1'b0), 32'(WAIT));
        reset = 1'b1;
        #1;
        chk_reset_outputs(1'b0);
        @(negedge clk);
        chk_reset_outputs(1'b0);
        reset = 1'b0;
        @(negedge clk);
        txn(1'b0, 1'b0, 32'd96, 32'd0, 0, 1'b0, t1);

        // Request held during WAIT/RESP with changing payload is served once.
        txn(1'b0, 1'b0, 32'd100, 32'd0, 2, 1'b1, t1);
        txn(1'b0, 1'b0, 32'd96, 32'd0, 0, 1'b0, t1);
        txn(1'b0, 1'b0, 32'd100, 32'd0, 0, 1'b0, t1);

        // Zero wait states, back to back.
        txn(1'b1, 1'b1, 32'd4, 32'd3, 0, 1'b0, t1);
        txn(1'b1, 1'b0, 32'd4, 32'd0, 0, 1'b0, t2);
        chk("throughput_w0", 32'((t2 - t1) / 10), 32'd2);

        // Random traffic on both instances.
        for (int n = 0; n < 30; n++)
            txn(1'b0, 1'($urandom_range(0, 1)), rand_addr(), $urandom,
                $urandom_range(0, 3), 1'($urandom_range(0, 3) == 0), t1);
        for (int n = 0; n < 30; n++)
            txn(1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom,
                $urandom_range(0, 3), 1'b0, t1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
